// File: rtl/ddr_capture_pkg.sv
// Shared types and constants for the DDR byte-pair capture stage.
package ddr_capture_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    CAPTURE
  } cap_state_e;

  // Byte lane (LSB = lane 0) each sample lands in within the packed word.
  localparam int unsigned LANE_EVEN_IN0 = 0;
  localparam int unsigned LANE_EVEN_IN1 = 1;
  localparam int unsigned LANE_ODD_IN0  = 2;
  localparam int unsigned LANE_ODD_IN1  = 3;

  function automatic logic [WORD_W-1:0] pack_word(
    input logic [BYTE_W-1:0] even_in0,
    input logic [BYTE_W-1:0] even_in1,
    input logic [BYTE_W-1:0] odd_in0,
    input logic [BYTE_W-1:0] odd_in1
  );
    logic [WORD_W-1:0] w;
    w = '0;
    w[LANE_EVEN_IN0*BYTE_W +: BYTE_W] = even_in0;
    w[LANE_EVEN_IN1*BYTE_W +: BYTE_W] = even_in1;
    w[LANE_ODD_IN0*BYTE_W  +: BYTE_W] = odd_in0;
    w[LANE_ODD_IN1*BYTE_W  +: BYTE_W] = odd_in1;
    return w;
  endfunction

endpackage

// File: rtl/ddr_capture_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO succeeds only alongside a pop.
module ddr_capture_fifo
  import ddr_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  // Gate the head so data reads as zero whenever nothing is buffered.
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ddr_capture_8.sv
// Skips a programmable number of pad cycles, then packs DDR byte pairs into
// little-endian words buffered in a FIFO; overrun is flagged, never stalled.
module ddr_capture_8
  import ddr_capture_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned SKIP_W     = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [7:0]        in0,
  input  logic [7:0]        in1,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [SKIP_W-1:0] skip,
  output logic              busy,
  output logic              done,
  output logic [31:0]       data,
  output logic              valid,
  input  logic              ready,
  output logic              overflow
);

  cap_state_e          state_q, state_d;
  logic                phase_q, phase_d;
  logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
  logic [LEN_W-1:0]    words_q, words_d;
  logic [2*BYTE_W-1:0] hold_q, hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;

  logic                push, pop;
  logic [WORD_W-1:0]   push_data;
  logic                fifo_empty, fifo_full;

  assign push      = (state_q == CAPTURE) && phase_q;
  assign pop       = ready && !fifo_empty;
  assign push_data = pack_word(hold_q[BYTE_W-1:0], hold_q[2*BYTE_W-1:BYTE_W], in0, in1);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    skip_cnt_d = skip_cnt_q;
    words_d    = words_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;

    if (push && fifo_full && !pop) overflow_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        // Also retires the one-cycle busy left by a zero-length command.
        busy_d = 1'b0;
        if (start && !busy_q) begin
          busy_d     = 1'b1;
          overflow_d = 1'b0;
          words_d    = len;
          skip_cnt_d = skip;
          phase_d    = 1'b0;
          if (len == '0)       done_d  = 1'b1;
          else if (skip != '0) state_d = SKIP;
          else                 state_d = CAPTURE;
        end
      end
      SKIP: begin
        skip_cnt_d = skip_cnt_q - SKIP_W'(1);
        if (skip_cnt_q == SKIP_W'(1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          hold_d = {in1, in0};
        end else begin
          words_d = words_q - LEN_W'(1);
          if (words_q == LEN_W'(1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      skip_cnt_q <= '0;
      words_q    <= '0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      skip_cnt_q <= skip_cnt_d;
      words_q    <= words_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  ddr_capture_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign valid    = !fifo_empty;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule
